// File: rtl/clk_div_ctrl.sv
// Programmable clock divider with start/stop control and a ratio handshake.
// Define CLK_DIV_CTRL_ERRCHK_EN to reject ratios below 2 with an err pulse instead of clamping them.
module clk_div_ctrl #(
    parameter int unsigned      WIDTH   = 32,
    parameter logic [WIDTH-1:0] DEF_DIV = WIDTH'(10_000_000)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] cfg_div,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    output logic             clk_out,
    output logic             tick,
    output logic             busy,
    output logic             err
);

    typedef enum logic [1:0] {IDLE, RUN, PEND, STOPW} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic             xfer, store, at_end;
    logic [WIDTH-1:0] cfg_val, cnt_inc;

    assign cfg_ready = (state_q == IDLE) || (state_q == RUN);
    assign busy      = (state_q != IDLE);
    assign clk_out   = clk_out_q;
    assign tick      = tick_q;
    assign xfer      = cfg_valid && cfg_ready;
    assign at_end    = (cnt_q == div_q - WIDTH'(1));
    assign cnt_inc   = at_end ? '0 : cnt_q + WIDTH'(1);

`ifdef CLK_DIV_CTRL_ERRCHK_EN
    logic err_q;

    assign cfg_val = cfg_div;
    assign store   = xfer && (cfg_div >= WIDTH'(2));
    assign err     = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= xfer && (cfg_div < WIDTH'(2));
    end
`else
    assign cfg_val = (cfg_div < WIDTH'(2)) ? WIDTH'(2) : cfg_div;
    assign store   = xfer;
    assign err     = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (store) div_d = cfg_val;
                if (start && !stop) state_d = RUN;
            end
            RUN: begin
                cnt_d = cnt_inc;
                if (store) begin
                    pend_d     = cfg_val;
                    pend_vld_d = 1'b1;
                end
                if (stop)       state_d = STOPW;
                else if (store) state_d = PEND;
            end
            PEND: begin
                cnt_d = cnt_inc;
                if (stop) begin
                    state_d = STOPW;
                end else if (at_end) begin
                    div_d      = pend_q;
                    pend_vld_d = 1'b0;
                    state_d    = RUN;
                end
            end
            STOPW: begin
                cnt_d = cnt_inc;
                if (at_end) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    if (pend_vld_q) begin
                        div_d      = pend_q;
                        pend_vld_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Outputs are computed from next-state values so the flops line up with cnt_q.
        clk_out_d = (state_d != IDLE) && (cnt_d >= (div_d >> 1));
        tick_d    = (state_d != IDLE) && (cnt_d == div_d - WIDTH'(1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            div_q      <= DEF_DIV;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            clk_out_q  <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            clk_out_q  <= clk_out_d;
            tick_q     <= tick_d;
        end
    end

endmodule
